// File: rtl/gshare_pkg.sv
// gshare_pkg
//   Shared types and helpers for the gshare branch predictor.
//   bp_cnt_t    : 2-bit saturating direction counter
//   SNT/WNT/WT/ST : strongly/weakly not-taken, weakly/strongly taken
//   sat_update  : one training step of a counter toward the actual outcome
package gshare_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t SNT = 2'b00;
  localparam bp_cnt_t WNT = 2'b01;
  localparam bp_cnt_t WT  = 2'b10;
  localparam bp_cnt_t ST  = 2'b11;

  // Move one step toward the outcome, saturating at both ends.
  function automatic bp_cnt_t sat_update(bp_cnt_t c, logic taken);
    bp_cnt_t r;
    if (taken) begin
      r = (c == ST) ? ST : bp_cnt_t'(c + 2'b01);
    end else begin
      r = (c == SNT) ? SNT : bp_cnt_t'(c - 2'b01);
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// gshare_pht
//   Pattern history table: 2^IDX_W 2-bit saturating counters.
//   One asynchronous read port (returns the counter MSB = predicted direction)
//   and one synchronous write port that applies a saturating training step.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset (all counters -> CNT_RESET)
//     i_rd_idx       : read index
//     o_rd_taken     : MSB of the counter at i_rd_idx (combinational)
//     i_wr_en        : apply a training step this cycle
//     i_wr_idx       : counter to train
//     i_wr_taken     : actual outcome to train toward
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int      IDX_W     = 7,
  parameter bp_cnt_t CNT_RESET = WNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  bp_cnt_t r_pht [DEPTH];

  // Read is purely combinational and sees the pre-write value in a cycle
  // where the same entry is being trained; there is no bypass.
  assign o_rd_taken = r_pht[i_rd_idx][1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pht[i] <= CNT_RESET;
      end
    end else if (i_wr_en) begin
      r_pht[i_wr_idx] <= sat_update(r_pht[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Gshare direction predictor: PHT indexed by PC xor global history register.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     predict_valid       : fetch consumes a prediction this cycle (shifts GHR)
//     predict_pc          : PC of the branch being predicted
//     predict_taken       : predicted direction (combinational)
//     predict_history     : GHR used for this prediction (combinational)
//     train_valid         : resolved outcome presented
//     train_taken         : actual direction
//     train_mispredicted  : outcome differed from prediction (repairs GHR)
//     train_history       : GHR snapshot taken at prediction time
//     train_pc            : PC of the resolved branch
module gshare_branch_predictor
  import gshare_pkg::*;
#(
  parameter int      IDX_W     = 7,
  parameter bp_cnt_t CNT_RESET = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             predict_valid,
  input  logic [IDX_W-1:0] predict_pc,
  output logic             predict_taken,
  output logic [IDX_W-1:0] predict_history,
  input  logic             train_valid,
  input  logic             train_taken,
  input  logic             train_mispredicted,
  input  logic [IDX_W-1:0] train_history,
  input  logic [IDX_W-1:0] train_pc
);

  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W-1:0] w_p_idx;
  logic [IDX_W-1:0] w_t_idx;
  logic             w_pred_taken;

  assign w_p_idx = predict_pc ^ r_ghr;
  assign w_t_idx = train_pc ^ train_history;

  gshare_pht #(
    .IDX_W     (IDX_W),
    .CNT_RESET (CNT_RESET)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_p_idx),
    .o_rd_taken (w_pred_taken),
    .i_wr_en    (train_valid),
    .i_wr_idx   (w_t_idx),
    .i_wr_taken (train_taken)
  );

  assign predict_taken   = w_pred_taken;
  assign predict_history = r_ghr;

  // A mispredict repair rebuilds history from the snapshot plus the real
  // outcome; any same-cycle speculative shift belongs to flushed fetch work.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (train_valid && train_mispredicted) begin
      r_ghr <= {train_history[IDX_W-2:0], train_taken};
    end else if (predict_valid) begin
      r_ghr <= {r_ghr[IDX_W-2:0], w_pred_taken};
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  localparam int IDX_W = 7;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             predict_valid = 1'b0;
  logic [IDX_W-1:0] predict_pc = '0;
  logic             predict_taken;
  logic [IDX_W-1:0] predict_history;
  logic             train_valid = 1'b0;
  logic             train_taken = 1'b0;
  logic             train_mispredicted = 1'b0;
  logic [IDX_W-1:0] train_history = '0;
  logic [IDX_W-1:0] train_pc = '0;

  int errors = 0;
  int checks = 0;

  // Reference model: counters as small integers 0..3, history as an integer.
  int m_cnt [N];
  int m_ghr = 0;

  // Expected {taken, history} for each cycle where a prediction is consumed.
  logic [IDX_W:0] exp_q [$];

  gshare_branch_predictor #(.IDX_W(IDX_W), .CNT_RESET(2'b01)) dut (
    .clk                (clk),
    .reset              (reset),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .train_pc           (train_pc)
  );

  always #5 clk = ~clk;

  // Monitor: whenever fetch consumes a prediction, compare against the scoreboard.
  always @(negedge clk) begin
    if (predict_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL pred_unexpected: got taken=%0d hist=0x%02h, no expectation queued",
                 predict_taken, predict_history);
      end else begin
        logic [IDX_W:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({predict_taken, predict_history} !== e) begin
          errors++;
          $display("FAIL pred @%0t: got taken=%0d hist=0x%02h, expected taken=%0d hist=0x%02h",
                   $time, predict_taken, predict_history, e[IDX_W], e[IDX_W-1:0]);
        end
      end
    end
  end

  // One clock cycle of stimulus; the model advances with the edge.
  task automatic cyc(input logic rs, input logic pv, input int ppc,
                     input logic tv, input logic tt, input logic tm,
                     input int th, input int tpc);
    int  pidx, tidx;
    bit  ptaken;
    reset              = rs;
    predict_valid      = pv;
    predict_pc         = IDX_W'(ppc);
    train_valid        = tv;
    train_taken        = tt;
    train_mispredicted = tm;
    train_history      = IDX_W'(th);
    train_pc           = IDX_W'(tpc);
    pidx   = (ppc ^ m_ghr) % N;
    ptaken = (m_cnt[pidx] >= 2);
    if (pv) exp_q.push_back({ptaken, IDX_W'(m_ghr)});
    @(posedge clk);
    if (rs) begin
      m_ghr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 1;
    end else begin
      if (tv) begin
        tidx = (tpc ^ th) % N;
        if (tt) m_cnt[tidx] = (m_cnt[tidx] == 3) ? 3 : m_cnt[tidx] + 1;
        else    m_cnt[tidx] = (m_cnt[tidx] == 0) ? 0 : m_cnt[tidx] - 1;
      end
      if (tv && tm)  m_ghr = ((th * 2) + int'(tt)) % N;
      else if (pv)   m_ghr = ((m_ghr * 2) + int'(ptaken)) % N;
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pred(input int ppc);
    cyc(1'b0, 1'b1, ppc, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic train(input logic tt, input logic tm, input int th, input int tpc);
    cyc(1'b0, 1'b0, 0, 1'b1, tt, tm, th, tpc);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 1;
    #1;
    // Reset: first cycle state is unknown, second cycle outputs must be cleared.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 0);

    // Basic predict from reset state; not-taken outcome keeps GHR at 0.
    pred(5);
    pred(5);
    pred(5);

    // Train up to strongly taken, read back, then saturate.
    train(1'b1, 1'b0, 0, 5);
    train(1'b1, 1'b0, 0, 5);
    pred(5);                        // GHR=0 here -> taken, GHR becomes 1
    train(1'b1, 1'b0, 0, 5);
    pred(5 ^ m_ghr);

    // GHR repaired to 0x2A, read index 0, train down to 00 and hold.
    train(1'b0, 1'b1, 'h15, 0);
    pred('h2A);
    train(1'b0, 1'b0, 'h2A, 'h2A);
    train(1'b0, 1'b0, 'h2A, 'h2A);
    train(1'b0, 1'b0, 'h2A, 'h2A);
    pred(m_ghr);

    // Mispredict repair beats a same-cycle predict: GHR = 0x23.
    cyc(1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 'h11, 0);
    pred(0);

    // Same-cycle predict and train on index 0x10: no bypass.
    cyc(1'b0, 1'b1, 'h10 ^ m_ghr, 1'b1, 1'b1, 1'b0, 0, 'h10);
    pred('h10 ^ m_ghr);

    // Reset mid-operation beats a train; GHR set to 0x7F first.
    train(1'b1, 1'b1, 'h3F, 0);
    pred(5 ^ m_ghr);
    train(1'b1, 1'b1, 'h3F, 0);
    cyc(1'b1, 1'b1, 5 ^ m_ghr, 1'b1, 1'b1, 1'b0, 0, 5);
    pred(5);
    pred(0);

    // Randomized traffic; train history drawn either from real snapshots or random.
    for (int n = 0; n < 3000; n++) begin
      logic rs, pv, tv, tt, tm;
      int   ppc, th, tpc;
      rs  = ($urandom_range(0, 199) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      tv  = ($urandom_range(0, 2) != 0);
      tt  = $urandom_range(0, 1);
      tm  = ($urandom_range(0, 4) == 0);
      ppc = $urandom_range(0, N - 1);
      tpc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, N - 1);
      th  = ($urandom_range(0, 1) == 0) ? m_ghr : $urandom_range(0, N - 1);
      cyc(rs, pv, ppc, tv, tt, tm, th, tpc);
    end

    idle();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
